dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
Shares one single-ported data memory between the two issue slots of the dual-issue LEGv8 core.
- Captures a pair of memory requests (slot 1 = older instruction, slot 2 = younger) and serialises them in program order onto the memory port.
- Holds the pipeline via stall until both accesses complete, then returns load data per slot.
- Sits between the core's mem_address/mem_data/memread/memwrite outputs and Data_Memory.

Parameters:
ADDR_W, 64, byte address width
DATA_W, 64, data word width

Ports:
CLOCK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-high reset
req1_valid  in  1  slot 1 has a memory op this cycle
req1_write  in  1  slot 1 op is store (1) or load (0)
req1_addr  in  ADDR_W  slot 1 address
req1_wdata  in  DATA_W  slot 1 store data
req2_valid, req2_write, req2_addr, req2_wdata  in  1/1/ADDR_W/DATA_W  same fields for slot 2
stall  out  1  pipeline must hold the current pair stable
done  out  1  one-cycle pulse: pair complete, rdata valid
rdata1  out  DATA_W  slot 1 load result
rdata2  out  DATA_W  slot 2 load result
mem_req  out  1  memory access request
mem_write  out  1  access is store
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory store data
mem_ack  in  1  memory accepted or completed the access; mem_rdata valid this cycle
mem_rdata  in  DATA_W  memory load data

Behaviour:
- Clock and reset: single clock CLOCK; RESET is asynchronous and active-high.
- Reset values: state=IDLE; stall=0; done=0; mem_req=0; mem_write=0; mem_addr=0; mem_wdata=0; rdata1=0; rdata2=0; latched requests cleared.
- States: IDLE, ACC1, ACC2, DONE.
- IDLE:
  - Neither valid: stay in IDLE, stall=0.
  - Any valid: latch both slots' fields. stall=1 combinationally in this same cycle.
  - Next state: ACC1 if req1_valid, else ACC2.
- ACC1:
  - Drives mem_req=1 with the latched slot-1 write/addr/wdata, held stable until mem_ack.
  - mem_ack may arrive in the same cycle as mem_req (zero-wait memory).
  - On ack: if the slot is a load, capture mem_rdata into rdata1; if a store, rdata1=0.
  - Next state on ack: ACC2 if slot 2 is valid, else DONE.
- ACC2: same as ACC1 for slot 2 into rdata2. Next state on ack: DONE.
- DONE: done=1 and stall=0 for exactly one cycle; next state IDLE.
  - The pipeline advances on this edge, so fresh requests are not sampled in DONE.
  - IDLE samples the next pair on the following cycle.
- Stall: stall=1 in ACC1 and ACC2, and in IDLE whenever any valid is high.
- Rdata holding:
  - rdata1/rdata2 hold their value until overwritten by the next ack for that slot.
  - An unused slot's rdata is forced to 0 when the pair latches.
- Latency with zero-wait memory: single op = 3 cycles from valid to done; pair = 4 cycles. Each wait cycle on mem_ack adds 1.
- Ordering: slot 1 always completes before slot 2. A slot-1 store followed by a slot-2 load to the same address returns the stored value; no forwarding logic is needed.
- mem_ack outside ACC1/ACC2 is ignored.
- mem_write, mem_addr and mem_wdata are 0 whenever mem_req=0.
- Requests changing while stall=1 are ignored (latched copy used).
- Reset mid-access: all outputs go to reset values immediately. The in-flight access is abandoned and memory must tolerate a dropped request.
- No address alignment check; addresses are passed through unmodified.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined: adds output ports conflict_cnt [31:0] and wait_cnt [31:0].
  - conflict_cnt increments once per latched pair with both slots valid.
  - wait_cnt increments each ACC1/ACC2 cycle with mem_req=1 and mem_ack=0.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package dmem_arb_pkg:
  - State encoding constants IDLE=2'd0, ACC1=2'd1, ACC2=2'd2, DONE=2'd3.
  - Slot index constants SLOT1=1'b0, SLOT2=1'b1.
  - Counter width constant STATS_W=32.
- Sub-module dmem_arb_slot_reg, instantiated twice: latches valid/write/addr/wdata per slot on the IDLE capture strobe and holds the rdata register.
- The FSM and output mux stay in the top level.

Test Plan:
- Reset, then req1 load addr 0x10 with memory holding 0xDEAD at 0x10 (zero-wait), no slot 2 -> stall 1 for 2 cycles, done on cycle 3, rdata1=0xDEAD, rdata2=0.
- Slot 1 store 0x55 to 0x20, slot 2 load 0x20 -> mem_req sequence store then load; rdata2=0x55; done on cycle 4.
- Slot 2 only, load 0x08 holding 0x1234 -> ACC1 skipped; rdata1=0; rdata2=0x1234; done on cycle 3.
- Pair with mem_ack delayed 2 cycles on each access -> done on cycle 8; mem_addr and mem_wdata stable while waiting; stall continuous until done.
- Assert RESET during ACC2 -> mem_req, stall and done drop to 0 in the same cycle; state returns to IDLE; a subsequent single load completes normally.
- With DMEM_ARB_STATS_EN defined: 3 dual-op pairs, 5 total ack-wait cycles -> conflict_cnt=3, wait_cnt=5.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// ============================================================================
// dmem_arb_pkg : shared types and constants for dmem_port_arbiter
// Revision     : 1.0
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic SLOT1   = 1'b0;
    localparam logic SLOT2   = 1'b1;
    localparam int   STATS_W = 32;

endpackage

`default_nettype wire

// File: rtl/dmem_port_arbiter_if.sv
// ============================================================================
// dmem_port_arbiter_if : core request pair, pipeline handshake and memory port
// Revision             : 1.0
// ============================================================================
`default_nettype none

interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              req1_valid;
    logic              req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req2_valid;
    logic              req2_write;
    logic [ADDR_W-1:0] req2_addr;
    logic [DATA_W-1:0] req2_wdata;
    logic              stall;
    logic              done;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              mem_req;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        input  req2_valid, req2_write, req2_addr, req2_wdata,
        input  mem_ack, mem_rdata,
        output stall, done, rdata1, rdata2,
        output mem_req, mem_write, mem_addr, mem_wdata
    );

    // Core / memory side
    modport master (
        output req1_valid, req1_write, req1_addr, req1_wdata,
        output req2_valid, req2_write, req2_addr, req2_wdata,
        output mem_ack, mem_rdata,
        input  stall, done, rdata1, rdata2,
        input  mem_req, mem_write, mem_addr, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/dmem_arb_slot_reg.sv
// ============================================================================
// dmem_arb_slot_reg : per-slot request latch and load-result register
// Revision          : 1.0
// ============================================================================
`default_nettype none

module dmem_arb_slot_reg #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              capture,
    input  wire logic              in_valid,
    input  wire logic              in_write,
    input  wire logic [ADDR_W-1:0] in_addr,
    input  wire logic [DATA_W-1:0] in_wdata,
    input  wire logic              ack,
    input  wire logic [DATA_W-1:0] mem_rdata,
    output logic                   valid,
    output logic                   write,
    output logic [ADDR_W-1:0]      addr,
    output logic [DATA_W-1:0]      wdata,
    output logic [DATA_W-1:0]      rdata
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            write <= 1'b0;
            addr  <= '0;
            wdata <= '0;
            rdata <= '0;
        end else if (capture) begin
            valid <= in_valid;
            write <= in_write;
            addr  <= in_addr;
            wdata <= in_wdata;
            // An idle slot reports zero; a used slot keeps its old result until acked.
            if (!in_valid) begin
                rdata <= '0;
            end
        end else if (ack) begin
            rdata <= write ? '0 : mem_rdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
// ============================================================================
// dmem_port_arbiter : serialises a dual-issue memory pair onto one memory port
// Optional macro    : DMEM_ARB_STATS_EN adds conflict_cnt / wait_cnt outputs
// Revision          : 1.0
// ============================================================================
`default_nettype none

module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  wire logic             CLOCK,
    input  wire logic             RESET,
    dmem_port_arbiter_if.slave    bus
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0]    conflict_cnt,
    output logic [STATS_W-1:0]    wait_cnt
`endif
);

    state_t            state;
    state_t            state_nx;
    logic              capture;
    logic [1:0]        ack;
    logic [1:0]        slot_valid;
    logic [1:0]        slot_write;
    logic [ADDR_W-1:0] slot_addr  [2];
    logic [DATA_W-1:0] slot_wdata [2];
    logic [DATA_W-1:0] slot_rdata [2];

    dmem_arb_slot_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot1 (
        .clk       (CLOCK),
        .rst       (RESET),
        .capture   (capture),
        .in_valid  (bus.req1_valid),
        .in_write  (bus.req1_write),
        .in_addr   (bus.req1_addr),
        .in_wdata  (bus.req1_wdata),
        .ack       (ack[SLOT1]),
        .mem_rdata (bus.mem_rdata),
        .valid     (slot_valid[SLOT1]),
        .write     (slot_write[SLOT1]),
        .addr      (slot_addr[SLOT1]),
        .wdata     (slot_wdata[SLOT1]),
        .rdata     (slot_rdata[SLOT1])
    );

    dmem_arb_slot_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot2 (
        .clk       (CLOCK),
        .rst       (RESET),
        .capture   (capture),
        .in_valid  (bus.req2_valid),
        .in_write  (bus.req2_write),
        .in_addr   (bus.req2_addr),
        .in_wdata  (bus.req2_wdata),
        .ack       (ack[SLOT2]),
        .mem_rdata (bus.mem_rdata),
        .valid     (slot_valid[SLOT2]),
        .write     (slot_write[SLOT2]),
        .addr      (slot_addr[SLOT2]),
        .wdata     (slot_wdata[SLOT2]),
        .rdata     (slot_rdata[SLOT2])
    );

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        capture       = 1'b0;
        ack           = 2'b00;
        bus.stall     = 1'b0;
        bus.done      = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state)
            IDLE: begin
                if (bus.req1_valid || bus.req2_valid) begin
                    capture   = 1'b1;
                    bus.stall = 1'b1;
                    state_nx  = bus.req1_valid ? ACC1 : ACC2;
                end
            end
            ACC1: begin
                bus.stall     = 1'b1;
                bus.mem_req   = 1'b1;
                bus.mem_write = slot_write[SLOT1];
                bus.mem_addr  = slot_addr[SLOT1];
                bus.mem_wdata = slot_wdata[SLOT1];
                if (bus.mem_ack) begin
                    ack[SLOT1] = 1'b1;
                    state_nx   = slot_valid[SLOT2] ? ACC2 : DONE;
                end
            end
            ACC2: begin
                bus.stall     = 1'b1;
                bus.mem_req   = 1'b1;
                bus.mem_write = slot_write[SLOT2];
                bus.mem_addr  = slot_addr[SLOT2];
                bus.mem_wdata = slot_wdata[SLOT2];
                if (bus.mem_ack) begin
                    ack[SLOT2] = 1'b1;
                    state_nx   = DONE;
                end
            end
            DONE: begin
                // Pipeline advances on this edge; new requests wait for IDLE.
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.rdata1 = slot_rdata[SLOT1];
    assign bus.rdata2 = slot_rdata[SLOT2];

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            conflict_cnt <= '0;
            wait_cnt     <= '0;
        end else begin
            if (capture && bus.req1_valid && bus.req2_valid && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
            if (bus.mem_req && !bus.mem_ack && (wait_cnt != '1)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// ============================================================================
// tb_dmem_port_arbiter : directed + randomized pairs against a memory model
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] conflict_cnt;
    logic [31:0] wait_cnt;
    int          exp_conf = 0;
    int          exp_wait = 0;
`endif

    dmem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bus)
`ifdef DMEM_ARB_STATS_EN
        ,
        .conflict_cnt (conflict_cnt),
        .wait_cnt     (wait_cnt)
`endif
    );

    function automatic logic [63:0] init_val(input int i);
        if (i == 2) return 64'hDEAD;
        if (i == 1) return 64'h1234;
        return 64'hA5A5_0000_0000_0000 ^ (64'(i) * 64'h0101_0101);
    endfunction

    // Memory responder: per-access wait counts, zero-wait ack is combinational.
    logic [63:0] resp_mem [128];
    int          wait_a = 0;
    int          wait_b = 0;
    int          op_idx;
    int          wait_ctr;
    int          cur_wait;

    assign cur_wait      = (op_idx == 0) ? wait_a : wait_b;
    assign bus.mem_ack   = bus.mem_req && (wait_ctr == cur_wait);
    assign bus.mem_rdata = resp_mem[bus.mem_addr[9:3]];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            op_idx   <= 0;
            wait_ctr <= 0;
            for (int i = 0; i < 128; i++) resp_mem[i] <= init_val(i);
        end else begin
            if (!bus.mem_req || bus.mem_ack) wait_ctr <= 0;
            else                             wait_ctr <= wait_ctr + 1;
            if (bus.done)                        op_idx <= 0;
            else if (bus.mem_req && bus.mem_ack) op_idx <= op_idx + 1;
            if (bus.mem_req && bus.mem_ack && bus.mem_write)
                resp_mem[bus.mem_addr[9:3]] <= bus.mem_wdata;
        end
    end

    // Reference memory advanced in program order, one pair at a time.
    logic [63:0] ref_mem [128];

    task automatic init_ref();
        for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit v1, w1, input logic [63:0] a1, d1,
                           input bit v2, w2, input logic [63:0] a2, d2);
        bus.req1_valid = v1; bus.req1_write = w1; bus.req1_addr = a1; bus.req1_wdata = d1;
        bus.req2_valid = v2; bus.req2_write = w2; bus.req2_addr = a2; bus.req2_wdata = d2;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_stall"},   64'(bus.stall),   64'd0);
        check({tag, "_done"},    64'(bus.done),    64'd0);
        check({tag, "_mem_req"}, 64'(bus.mem_req), 64'd0);
        check({tag, "_mem_addr"}, bus.mem_addr,    64'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata,  64'd0);
    endtask

    // Called just after a falling edge with the arbiter idle.
    task automatic run_pair(input bit v1, w1, input logic [63:0] a1, d1,
                            input bit v2, w2, input logic [63:0] a2, d2,
                            input int wa, wb);
        logic [63:0] e1, e2;
        int n1, n2, w2nd, lat, done_c;
        e1 = 64'd0; e2 = 64'd0;
        if (v1) begin
            e1 = w1 ? 64'd0 : ref_mem[a1[9:3]];
            if (w1) ref_mem[a1[9:3]] = d1;
        end
        if (v2) begin
            e2 = w2 ? 64'd0 : ref_mem[a2[9:3]];
            if (w2) ref_mem[a2[9:3]] = d2;
        end
        w2nd = v1 ? wb : wa;
        n1   = v1 ? 1 + wa : 0;
        n2   = v2 ? 1 + w2nd : 0;
        lat  = 2 + n1 + n2;
`ifdef DMEM_ARB_STATS_EN
        if (v1 && v2) exp_conf++;
        exp_wait += (v1 ? wa : 0) + (v2 ? w2nd : 0);
`endif
        wait_a = wa; wait_b = wb;
        set_req(v1, w1, a1, d1, v2, w2, a2, d2);
        #1;
        check("c1_stall", 64'(bus.stall), 64'd1);
        check("c1_mem_req", 64'(bus.mem_req), 64'd0);
        done_c = 0;
        for (int c = 2; c <= lat + 4 && done_c == 0; c++) begin
            @(posedge clk); #1;
            // Inputs wander while stalled; only the latched copy may be used.
            set_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom},
                    {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    {$urandom, $urandom}, {$urandom, $urandom});
            @(negedge clk); #1;
            if (bus.done) begin
                done_c = c;
            end else begin
                check("acc_stall", 64'(bus.stall), 64'd1);
                if (c - 2 < n1) begin
                    check("op1_req",   64'(bus.mem_req),   64'd1);
                    check("op1_write", 64'(bus.mem_write), 64'(w1));
                    check("op1_addr",  bus.mem_addr,       a1);
                    if (w1) check("op1_wdata", bus.mem_wdata, d1);
                end else if (c - 2 < n1 + n2) begin
                    check("op2_req",   64'(bus.mem_req),   64'd1);
                    check("op2_write", 64'(bus.mem_write), 64'(w2));
                    check("op2_addr",  bus.mem_addr,       a2);
                    if (w2) check("op2_wdata", bus.mem_wdata, d2);
                end
            end
        end
        check("done_cycle", 64'(done_c), 64'(lat));
        check("done_stall", 64'(bus.stall), 64'd0);
        check("done_mem_req", 64'(bus.mem_req), 64'd0);
        check("rdata1", bus.rdata1, e1);
        check("rdata2", bus.rdata2, e2);
        set_req(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
        @(negedge clk); #1;
        check_idle("post");
        check("hold_rdata1", bus.rdata1, e1);
        check("hold_rdata2", bus.rdata2, e2);
    endtask

    initial begin
        bit          v1, v2, w1, w2;
        logic [63:0] a1, a2;
        init_ref();
        set_req(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check_idle("reset");
        check("reset_rdata1", bus.rdata1, 64'd0);
        check("reset_rdata2", bus.rdata2, 64'd0);
        rst = 1'b0;
        @(negedge clk); #1;
        check_idle("idle");

        run_pair(1, 0, 64'h10, 64'h0,  0, 0, 64'h0,  64'h0, 0, 0);
        run_pair(1, 1, 64'h20, 64'h55, 1, 0, 64'h20, 64'h0, 0, 0);
        run_pair(0, 0, 64'h0,  64'h0,  1, 0, 64'h08, 64'h0, 0, 0);
        run_pair(1, 0, 64'h18, 64'h0,  1, 1, 64'h28, 64'h77, 2, 2);

        // Reset while slot 2 is waiting on the memory.
        wait_a = 0; wait_b = 3;
        set_req(1, 0, 64'h30, 64'h0, 1, 0, 64'h38, 64'h0);
        @(posedge clk); #1;
        @(negedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk); #1;
        check("rst_acc2_req",  64'(bus.mem_req), 64'd1);
        check("rst_acc2_addr", bus.mem_addr, 64'h38);
        check("rst_acc2_rdata1", bus.rdata1, ref_mem[6]);
        rst = 1'b1;
        set_req(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
        #1;
        check_idle("rst_mid");
        check("rst_mid_rdata1", bus.rdata1, 64'd0);
        init_ref();
`ifdef DMEM_ARB_STATS_EN
        exp_conf = 0; exp_wait = 0;
        check("rst_conflict_cnt", 64'(conflict_cnt), 64'd0);
        check("rst_wait_cnt", 64'(wait_cnt), 64'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle("rst_release");
        run_pair(1, 0, 64'h10, 64'h0, 0, 0, 64'h0, 64'h0, 1, 0);

        for (int t = 0; t < 30; t++) begin
            v1 = 1'($urandom_range(0, 1));
            v2 = v1 ? 1'($urandom_range(0, 1)) : 1'b1;
            w1 = 1'($urandom_range(0, 1));
            w2 = 1'($urandom_range(0, 1));
            a1 = {57'd0, 4'($urandom_range(0, 15)), 3'b000};
            a2 = {57'd0, 4'($urandom_range(0, 15)), 3'b000};
            run_pair(v1, w1, a1, {$urandom, $urandom}, v2, w2, a2, {$urandom, $urandom},
                     $urandom_range(0, 2), $urandom_range(0, 2));
        end

`ifdef DMEM_ARB_STATS_EN
        check("conflict_cnt", 64'(conflict_cnt), 64'(exp_conf));
        check("wait_cnt", 64'(wait_cnt), 64'(exp_wait));
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
